// File: rtl/k12a_alu_shift_seq.sv
// k12a_alu_shift_seq: multi-cycle shift sequencer that borrows the K12A ALU.
// Shifts an 8-bit operand by 0-7 positions (SHL or SRA), one single-bit
// ALU operation per cycle, capturing each ALU result from data_bus.
// Optional feature macro: K12A_ALU_SHIFT_SEQ_SHIFTOUT_EN (registers the last
// bit shifted out on shift_out; when undefined shift_out is tied to 0).
//
// Handshake: start is sampled only in IDLE. The operation is accepted on
// that edge and busy rises in the next cycle. done is a one-cycle pulse
// with result (and shift_out) valid in the same cycle. start seen while
// busy is ignored, so a held start can only launch a new operation from IDLE.

package k12a_alu_pkg;
  typedef enum logic [1:0] {
    ALU_OPERAND_SEL_B    = 2'b00,
    ALU_OPERAND_SEL_IMM  = 2'b01,
    ALU_OPERAND_SEL_ZERO = 2'b10
  } alu_operand_sel_t;
endpackage

module k12a_alu_shift_seq
  import k12a_alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [2:0]       count,
  input  logic [7:0]       operand,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             shift_out,
  output logic             alu_load,
  output alu_operand_sel_t alu_operand_sel,
  output logic             alu_subtract,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [15:0]      alu_inst,
  input  logic [7:0]       data_bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ALU inst encodings: bits [10:8] select the operation.
  localparam logic [15:0] INST_SHL = 16'h0400;  // acc + acc
  localparam logic [15:0] INST_SRA = 16'h0600;  // arithmetic shift right

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_acc;
  logic [2:0]  r_remaining;
  logic        r_op_q;
  logic [7:0]  r_result;
  logic        w_accept;
  logic        w_last_step;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_step = (r_state == S_STEP) && (r_remaining == 3'd1);

  // Next-state logic: a zero count skips STEP and goes straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (count != 3'd0) ? S_STEP : S_DONE;
      S_STEP:  if (r_remaining == 3'd1) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU drive: only STEP owns the bus; every other state presents zeros.
  always_comb begin
    alu_load        = 1'b0;
    alu_operand_sel = ALU_OPERAND_SEL_B;
    alu_subtract    = 1'b0;
    alu_a           = 8'h00;
    alu_b           = 8'h00;
    alu_inst        = 16'h0000;
    if (r_state == S_STEP) begin
      alu_load = 1'b1;
      alu_a    = r_acc;
      alu_b    = r_acc;
      alu_inst = r_op_q ? INST_SRA : INST_SHL;
    end
  end

  // Datapath and state register; result is loaded on the edge entering DONE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= 8'h00;
      r_remaining <= 3'd0;
      r_op_q      <= 1'b0;
      r_result    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc       <= operand;
        r_op_q      <= op;
        r_remaining <= count;
        if (count == 3'd0) r_result <= operand;
      end else if (r_state == S_STEP) begin
        r_acc       <= data_bus;
        r_remaining <= r_remaining - 3'd1;
        if (w_last_step) r_result <= data_bus;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign o_dbg_state = r_state;

`ifdef K12A_ALU_SHIFT_SEQ_SHIFTOUT_EN
  logic r_shift_out;

  // Departing bit of each step; the final step's bit is what remains visible.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shift_out <= 1'b0;
    end else if (w_accept) begin
      r_shift_out <= 1'b0;
    end else if (r_state == S_STEP) begin
      r_shift_out <= r_op_q ? r_acc[0] : r_acc[7];
    end
  end

  assign shift_out = r_shift_out;
`else
  assign shift_out = 1'b0;
`endif

endmodule
